spi_slave_ctrl: RTL and testbench

SPI_SLAVE_CTRL -- requirements
Module: spi_slave_ctrl

---
 rtl/spi_slave_ctrl_if.sv | 34 +++
 rtl/spi_slave_ctrl.sv | 122 ++++++++++++
 tb/tb_spi_slave_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_ctrl_if.sv
// SPI slave controller bus: SPI pins plus the RAM-side frame/read-data handshake.
interface spi_slave_ctrl_if #(
    parameter int ADDR_SIZE = 8
);
    logic                 SS_n;
    logic                 MOSI;
    logic                 MISO;
    logic [ADDR_SIZE+1:0] rx_data;
    logic                 rx_valid;
    logic [ADDR_SIZE-1:0] tx_data;
    logic                 tx_valid;

    // Controller side
    modport slave (
        input  SS_n,
        input  MOSI,
        output MISO,
        output rx_data,
        output rx_valid,
        input  tx_data,
        input  tx_valid
    );

    // SPI master / RAM side
    modport master (
        output SS_n,
        output MOSI,
        input  MISO,
        input  rx_data,
        input  rx_valid,
        output tx_data,
        output tx_valid
    );
endinterface

// File: rtl/spi_slave_ctrl.sv
// SPI slave controller: assembles ADDR_SIZE+2 bit frames for a RAM and
// serialises RAM read data back on MISO.
module spi_slave_ctrl #(
    parameter int ADDR_SIZE = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_slave_ctrl_if.slave bus
);
    localparam int CNT_W    = $clog2(ADDR_SIZE + 2);
    localparam int TX_CNT_W = $clog2(ADDR_SIZE + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  word_done;     // frame word captured, no more shifting
    logic [ADDR_SIZE:0]    rx_shreg;      // bits received so far, before bit 0
    logic [ADDR_SIZE+1:0]  rx_data;
    logic                  rx_valid;
    logic                  rd_addr_done;
    logic [ADDR_SIZE-1:0]  tx_shreg;
    logic [TX_CNT_W-1:0]   tx_cnt;        // bits still to present on MISO
    logic                  tx_busy;
    logic                  tx_fin;        // read byte already sent in this frame
    logic                  shifting;

    assign shifting = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state function; SS_n high always returns to IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!bus.SS_n) state_next = CHK_CMD;
            CHK_CMD: begin
                if (bus.SS_n)         state_next = IDLE;
                else if (!bus.MOSI)   state_next = WRITE;
                else if (rd_addr_done) state_next = READ_DATA;
                else                  state_next = READ_ADD;
            end
            default: if (bus.SS_n) state_next = IDLE;
        endcase
    end

    // Receive shift register; no reset needed, only meaningful mid-frame
    always_ff @(posedge clk) begin
        if (!bus.SS_n && ((state == CHK_CMD) || (shifting && !word_done)))
            rx_shreg <= {rx_shreg[ADDR_SIZE-1:0], bus.MOSI};
    end

    // Frame completion, read-address tracking and transmit serialiser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt      <= '0;
            word_done    <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rd_addr_done <= 1'b0;
            tx_shreg     <= '0;
            tx_cnt       <= '0;
            tx_busy      <= 1'b0;
            tx_fin       <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (bus.SS_n) begin
                // Abort: drop partial word and any transmit; rd_addr_done kept
                bit_cnt   <= '0;
                word_done <= 1'b0;
                tx_shreg  <= '0;
                tx_cnt    <= '0;
                tx_busy   <= 1'b0;
                tx_fin    <= 1'b0;
            end else if (state == CHK_CMD) begin
                bit_cnt   <= CNT_W'(ADDR_SIZE);
                word_done <= 1'b0;
            end else if (shifting && !word_done) begin
                if (bit_cnt == '0) begin
                    rx_data   <= {rx_shreg, bus.MOSI};
                    rx_valid  <= 1'b1;
                    word_done <= 1'b1;
                    if (state == READ_ADD) rd_addr_done <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt - 1'b1;
                end
            end else if (state == READ_DATA) begin
                if (tx_busy) begin
                    if (tx_cnt == TX_CNT_W'(1)) begin
                        tx_busy      <= 1'b0;
                        tx_fin       <= 1'b1;
                        tx_shreg     <= '0;
                        tx_cnt       <= '0;
                        rd_addr_done <= 1'b0;
                    end else begin
                        tx_shreg <= tx_shreg << 1;
                        tx_cnt   <= tx_cnt - 1'b1;
                    end
                end else if (!tx_fin && bus.tx_valid) begin
                    tx_shreg <= bus.tx_data;
                    tx_cnt   <= TX_CNT_W'(ADDR_SIZE);
                    tx_busy  <= 1'b1;
                end
            end
        end
    end

    assign bus.MISO     = tx_busy & tx_shreg[ADDR_SIZE-1];
    assign bus.rx_data  = rx_data;
    assign bus.rx_valid = rx_valid;
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: write, read-address/read-data, aborts, reset.
module tb_spi_slave_ctrl;
    localparam int AS = 8;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    logic [AS+1:0] last_rx;
    logic [AS-1:0] tx_pat;

    spi_slave_ctrl_if #(.ADDR_SIZE(AS)) bus ();

    spi_slave_ctrl #(.ADDR_SIZE(AS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drop SS_n, then present the first n bits of w MSB first, one per negedge
    task automatic start_bits(input logic [AS+1:0] w, input int n);
        @(negedge clk);
        bus.SS_n = 1'b0;
        bus.MOSI = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.MOSI = w[AS+1-i];
        end
    endtask

    // Full frame with strobe timing checks
    task automatic full_frame(input string tag, input logic [AS+1:0] w);
        start_bits(w, AS + 2);
        check({tag, "_vld_early"}, 32'(bus.rx_valid), 32'd0);
        @(negedge clk);
        check({tag, "_vld"}, 32'(bus.rx_valid), 32'd1);
        check({tag, "_data"}, 32'(bus.rx_data), 32'(w));
        @(negedge clk);
        check({tag, "_vld_1cyc"}, 32'(bus.rx_valid), 32'd0);
        last_rx = w;
    endtask

    task automatic end_frame();
        @(negedge clk);
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        bus.SS_n     = 1'b1;
        bus.MOSI     = 1'b0;
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        rst_n        = 1'b0;
        last_rx      = '0;
        repeat (2) @(negedge clk);
        check("rst_rx_data",  32'(bus.rx_data), 32'd0);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_miso",     32'(bus.MISO), 32'd0);
        check("rst_state",    32'(dut.state), 32'd0);
        check("rst_rdaddr",   32'(dut.rd_addr_done), 32'd0);
        rst_n = 1'b1;

        // Write address frame
        full_frame("wr_addr", 10'h0A5);
        check("wr_addr_state", 32'(dut.state), 32'd2);
        end_frame();

        // Write data frame; tx_valid outside READ_DATA must be ignored
        full_frame("wr_data", 10'h13C);
        bus.tx_data  = 8'hFF;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        check("wr_miso_a", 32'(bus.MISO), 32'd0);
        @(negedge clk);
        check("wr_miso_b", 32'(bus.MISO), 32'd0);
        end_frame();
        check("wr_rdaddr", 32'(dut.rd_addr_done), 32'd0);

        // Read address then read data
        full_frame("rd_addr", 10'h2A5);
        check("rd_addr_done_set", 32'(dut.rd_addr_done), 32'd1);
        end_frame();
        full_frame("rd_data", 10'h300);
        check("rd_data_state", 32'(dut.state), 32'd4);
        check("rd_miso_idle", 32'(bus.MISO), 32'd0);
        tx_pat       = 8'h3C;
        bus.tx_data  = tx_pat;
        bus.tx_valid = 1'b1;
        for (int i = AS - 1; i >= 0; i--) begin
            @(negedge clk);
            bus.tx_valid = 1'b0;
            bus.tx_data  = 8'h00;
            check($sformatf("rd_miso_b%0d", i), 32'(bus.MISO), 32'(tx_pat[i]));
        end
        @(negedge clk);
        check("rd_miso_after", 32'(bus.MISO), 32'd0);
        check("rd_addr_done_clr", 32'(dut.rd_addr_done), 32'd0);
        end_frame();

        // Abort after 5 data bits
        start_bits(10'h0FF, 7);
        end_frame();
        check("abort_state", 32'(dut.state), 32'd0);
        check("abort_vld",   32'(bus.rx_valid), 32'd0);
        check("abort_data",  32'(bus.rx_data), 32'(last_rx));

        // SS_n rising on the same edge as bit 0 capture
        start_bits(10'h055, AS + 2);
        bus.SS_n = 1'b1;
        @(negedge clk);
        check("late_abort_vld",   32'(bus.rx_valid), 32'd0);
        check("late_abort_data",  32'(bus.rx_data), 32'(last_rx));
        check("late_abort_state", 32'(dut.state), 32'd0);
        bus.MOSI = 1'b0;

        // Transmit aborted by SS_n; rd_addr_done must survive
        full_frame("rd2_addr", 10'h2A5);
        end_frame();
        full_frame("rd2_data", 10'h300);
        tx_pat       = 8'hA5;
        bus.tx_data  = tx_pat;
        bus.tx_valid = 1'b1;
        for (int i = AS - 1; i >= AS - 3; i--) begin
            @(negedge clk);
            bus.tx_valid = 1'b0;
            check($sformatf("rd2_miso_b%0d", i), 32'(bus.MISO), 32'(tx_pat[i]));
        end
        bus.SS_n = 1'b1;
        @(negedge clk);
        check("tx_abort_miso",   32'(bus.MISO), 32'd0);
        check("tx_abort_rdaddr", 32'(dut.rd_addr_done), 32'd1);
        check("tx_abort_state",  32'(dut.state), 32'd0);
        start_bits(10'h300, 2);
        check("reroute_state", 32'(dut.state), 32'd4);
        end_frame();

        // Asynchronous reset in the middle of a transmit
        full_frame("rd3_data", 10'h300);
        tx_pat       = 8'hC3;
        bus.tx_data  = tx_pat;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        @(negedge clk);
        check("rd3_miso_b6", 32'(bus.MISO), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_miso",   32'(bus.MISO), 32'd0);
        check("arst_state",  32'(dut.state), 32'd0);
        check("arst_rdaddr", 32'(dut.rd_addr_done), 32'd0);
        check("arst_rxdata", 32'(bus.rx_data), 32'd0);
        bus.SS_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Operation resumes after reset
        full_frame("post_rst", 10'h0A5);
        end_frame();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
